// File: rtl/group_accumulator_pkg.sv
// Shared defaults and sizing helpers for the group accumulator slice.
package group_accumulator_pkg;

  localparam int DW_DATA_DEF = 32;
  localparam int DW_ACC_DEF  = 48;

  // Counter width that stays legal when the group length is 1.
  function automatic int cnt_width(input int k_len);
    return (k_len > 1) ? $clog2(k_len) : 1;
  endfunction

endpackage

// File: rtl/group_accumulator_fifo.sv
// First-word-fall-through FIFO with occupancy output and synchronous flush.
module sync_fifo #(
  parameter  int DW    = 48,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage is reset too, so the head reads 0 straight out of reset;
  // clear only rewinds pointers and leaves stale words behind the empty flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/group_accumulator.sv
// Reduces each run of K_LEN valid words into one signed sum and queues the
// sums toward writeback; the input is never stalled, lost sums set overflow.
module group_accumulator
  import group_accumulator_pkg::*;
#(
  parameter  int DW_DATA = DW_DATA_DEF,
  parameter  int DW_ACC  = DW_ACC_DEF,
  parameter  int K_LEN   = 8,
  parameter  int DEPTH   = 4,
  localparam int DW_CNT  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DW_DATA-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_ACC-1:0] out_data,
  output logic [DW_CNT-1:0] level,
  output logic              busy,
  output logic              overflow
);

  localparam int            CW   = cnt_width(K_LEN);
  localparam logic [CW-1:0] LAST = CW'(K_LEN - 1);

  logic [CW-1:0]     cnt;
  logic [DW_ACC-1:0] acc;
  logic [DW_ACC-1:0] sum_next;
  logic              last_word;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;

  assign sum_next  = acc + DW_ACC'($signed(in_data));
  assign last_word = in_valid && (cnt == LAST);
  assign push      = last_word && !clear;
  assign pop       = !empty && out_ready && !clear;
  assign drop      = push && full && !pop;

  assign out_valid = !empty;
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        // The group restarts even when its completed sum has nowhere to go.
        if (cnt == LAST) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum_next;
          cnt <= cnt + CW'(1);
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DW    (DW_ACC),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .wdata   (sum_next),
    .pop     (pop),
    .rdata   (out_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

endmodule

// File: tb/tb_group_accumulator.sv
// Scoreboard bench for group_accumulator at K_LEN=4, DEPTH=4, 8-bit in, 16-bit sums.
module tb_group_accumulator;

  localparam int K_LEN   = 4;
  localparam int DEPTH   = 4;
  localparam int DW_DATA = 8;
  localparam int DW_ACC  = 16;
  localparam int DW_CNT  = $clog2(DEPTH + 1);

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b1;
  logic               clear     = 1'b0;
  logic               in_valid  = 1'b0;
  logic [DW_DATA-1:0] in_data   = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic [DW_ACC-1:0]  out_data;
  logic [DW_CNT-1:0]  level;
  logic               busy;
  logic               overflow;

  int tests = 0;
  int fails = 0;

  // Reference model: pending sums in FIFO order plus group state.
  logic [DW_ACC-1:0] exp_q[$];
  logic [DW_ACC-1:0] m_acc = '0;
  logic [DW_ACC-1:0] m_sum;
  int                m_cnt = 0;
  logic              m_ovf = 1'b0;
  int                m_occ;
  bit                m_pop;
  bit                mon_en = 1'b0;
  int                pops = 0;

  always #5 clk = ~clk;

  group_accumulator #(
    .DW_DATA (DW_DATA),
    .DW_ACC  (DW_ACC),
    .K_LEN   (K_LEN),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [DW_DATA-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic [DW_DATA-1:0] d);
    for (int i = 0; i < K_LEN; i++) send(d);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Mid-cycle monitor: checks state against the model, then applies this
  // cycle's inputs to the model exactly as the coming edge should.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      tests++;
      if (out_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL mon_out_valid got %b want %b", out_valid, exp_q.size() != 0);
      end
      tests++;
      if (level !== DW_CNT'(exp_q.size())) begin
        fails++;
        $display("FAIL mon_level got %0d want %0d", level, exp_q.size());
      end
      tests++;
      if (busy !== (m_cnt != 0)) begin
        fails++;
        $display("FAIL mon_busy got %b want %b", busy, m_cnt != 0);
      end
      tests++;
      if (overflow !== m_ovf) begin
        fails++;
        $display("FAIL mon_overflow got %b want %b", overflow, m_ovf);
      end
      if (clear) begin
        model_reset();
      end else begin
        m_occ = exp_q.size();
        m_pop = (m_occ > 0) && out_ready;
        if (m_pop) begin
          tests++;
          if (out_data !== exp_q[0]) begin
            fails++;
            $display("FAIL mon_out_data got %0h want %0h", out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          pops++;
        end
        if (in_valid) begin
          m_sum = m_acc + {{(DW_ACC-DW_DATA){in_data[DW_DATA-1]}}, in_data};
          if (m_cnt == K_LEN - 1) begin
            if (m_occ < DEPTH || m_pop) exp_q.push_back(m_sum);
            else m_ovf = 1'b1;
            m_acc = '0;
            m_cnt = 0;
          end else begin
            m_acc = m_sum;
            m_cnt++;
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    tests++;
    if ({out_valid, out_data, level, busy, overflow} !== '0) begin
      fails++;
      $display("FAIL %s got v=%b d=%0h l=%0d b=%b o=%b want all zero",
               tag, out_valid, out_data, level, busy, overflow);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_state("reset_state");
    step();
    step();
    #3 reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [DW_DATA-1:0] d;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = DW_DATA'(i);
      send(d);
      tests++;
      if (busy !== (i != 4)) begin
        fails++;
        $display("FAIL basic_busy_%0d got %b want %b", i, busy, i != 4);
      end
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'd10 || level !== 3'd1) begin
      fails++;
      $display("FAIL basic_sum got v=%b d=%0d l=%0d want v=1 d=10 l=1", out_valid, out_data, level);
    end
    idle(1);
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain got l=%0d v=%b want l=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_gaps();
    out_ready = 1'b0;
    send(-8'sd5); idle(2);
    send(8'sd3);  idle(1);
    send(-8'sd1); idle(3);
    send(8'sd2);
    tests++;
    if (out_data !== 16'hFFFF) begin
      fails++;
      $display("FAIL gaps_sum got %0h want ffff", out_data);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    send_group(8'h80);
    tests++;
    if (out_data !== 16'hFE00) begin
      fails++;
      $display("FAIL min_sum got %0h want fe00", out_data);
    end
    out_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) send_group(8'd1);
    tests++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_full got l=%0d o=%b want l=4 o=1", level, overflow);
    end
    pops = 0;
    out_ready = 1'b1;
    idle(6);
    tests++;
    if (pops != 4 || level !== 3'd0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drain got pops=%0d l=%0d o=%b want pops=4 l=0 o=1", pops, level, overflow);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int g = 1; g <= 4; g++) send_group(DW_DATA'(g));
    send(8'd5); send(8'd5); send(8'd5);
    out_ready = 1'b1;
    send(8'd5);
    tests++;
    if (level !== 3'd4 || overflow !== 1'b0 || out_data !== 16'd8) begin
      fails++;
      $display("FAIL full_push_pop got l=%0d o=%b d=%0d want l=4 o=0 d=8", level, overflow, out_data);
    end
    idle(5);
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL full_push_pop_drain got %0d want 0", level);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send(8'd7); send(8'd7);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd9;
    step();
    clear = 1'b0; in_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_busy got %b want 0", busy);
    end
    send_group(8'd1);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'd4) begin
      fails++;
      $display("FAIL clear_group got v=%b d=%0d want v=1 d=4", out_valid, out_data);
    end
    idle(1);
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) send_group(8'd2);
    tests++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL clear_fill got %0d want 3", level);
    end
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0;
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_fifo got l=%0d v=%b want l=0 v=0", level, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_group(8'd1);
    send(8'd3); send(8'd3);
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(8'd10); send(8'd20); send(8'd30); send(-8'sd5);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'd55) begin
      fails++;
      $display("FAIL post_reset_sum got v=%b d=%0d want v=1 d=55", out_valid, out_data);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
